// File: rtl/upload_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : upload_pkg
//  Description : Shared types and constants for the framed USB upload arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package upload_pkg;

    // Frame sequencer states, in emission order.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_H0   = 4'd1,
        ST_H1   = 4'd2,
        ST_ID   = 4'd3,
        ST_LENH = 4'd4,
        ST_LENL = 4'd5,
        ST_PAY  = 4'd6,
        ST_CSUM = 4'd7,
        ST_DONE = 4'd8
    } state_t;

    localparam logic [7:0] c_HDR0_DEF       = 8'hAA;
    localparam logic [7:0] c_HDR1_DEF       = 8'h44;

    // Header(2) + ID + LENH + LENL + CSUM wrapped around every payload.
    localparam int         c_FRAME_OVERHEAD = 6;

    localparam logic [2:0] c_ID_DSM         = 3'd0;
    localparam logic [2:0] c_ID_DC          = 3'd1;
    localparam logic [2:0] c_ID_I2C         = 3'd2;
    localparam logic [2:0] c_ID_UART        = 3'd3;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick: first requester at or after
//                the pointer, wrapping. Returns one-hot and encoded grant.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_SRC-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any_req
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;
    int               w_pos;

    // Scan the request vector starting at the pointer and stop at the first hit.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_req   = |i_req;
        w_found     = 1'b0;
        w_idx       = '0;
        w_pos       = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_pos = int'(i_ptr) + i;
            if (w_pos >= NUM_SRC) begin
                w_pos = w_pos - NUM_SRC;
            end
            w_idx = IDX_W'(w_pos);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/upload_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : upload_arbiter
//  Description : Round-robin sharing of the USB CDC upload byte stream among
//                NUM_SRC engines; each grant is wrapped as
//                HDR0 HDR1 ID LENH LENL payload CSUM.
//  Revision    : 1.0  initial release
// ============================================================================
module upload_arbiter
    import upload_pkg::*;
#(
    parameter int         NUM_SRC     = 4,
    parameter int         TIMEOUT_CYC = 4096,
    parameter logic [7:0] HDR0        = c_HDR0_DEF,
    parameter logic [7:0] HDR1        = c_HDR1_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    src_req,
    input  logic [16*NUM_SRC-1:0] src_len,
    input  logic [8*NUM_SRC-1:0]  src_data,
    input  logic [NUM_SRC-1:0]    src_valid,
    output logic [NUM_SRC-1:0]    src_ready,
    output logic [NUM_SRC-1:0]    src_done,
    output logic [7:0]            upload_data,
    output logic                  upload_valid,
    input  logic                  upload_ready,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int c_IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t               r_state,  w_state_nxt;
    logic [c_IDX_W-1:0]   r_g,      w_g_nxt;
    logic [c_IDX_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [15:0]          r_len,    w_len_nxt;
    logic [15:0]          r_rem,    w_rem_nxt;
    logic [7:0]           r_csum,   w_csum_nxt;
    logic [c_TMO_W-1:0]   r_tmo,    w_tmo_nxt;
    logic                 r_pad,    w_pad_nxt;
    logic [NUM_SRC-1:0]   r_done,   w_done_nxt;
    logic                 r_err,    w_err_nxt;
    logic [7:0]           r_upload_data;
    logic                 r_upload_valid;

    logic                 w_slot_free;
    logic                 w_load;
    logic [7:0]           w_byte;
    logic [NUM_SRC-1:0]   w_src_ready;
    logic                 w_pay_ok;
    logic [7:0]           w_id;
    logic [7:0]           w_src_byte;
    logic [NUM_SRC-1:0]   w_grant;
    logic [c_IDX_W-1:0]   w_grant_idx;
    logic                 w_any_req;
    logic [15:0]          w_grant_len;
    logic [15:0]          w_len_arr  [NUM_SRC];
    logic [7:0]           w_data_arr [NUM_SRC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_len_arr[gi]  = src_len[16*gi +: 16];
            assign w_data_arr[gi] = src_data[8*gi +: 8];
        end
    endgenerate

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (c_IDX_W)
    ) u_rr_arbiter (
        .i_req       (src_req),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_req   (w_any_req)
    );

    // Length of the source being granted, selected by the one-hot grant.
    always_comb begin
        w_grant_len = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant[i]) begin
                w_grant_len = w_grant_len | w_len_arr[i];
            end
        end
    end

    assign w_slot_free = !r_upload_valid || upload_ready;
    assign w_id        = 8'(r_g);
    assign w_src_byte  = w_data_arr[r_g];
    assign w_pay_ok    = (r_state == ST_PAY) && !r_pad && w_slot_free && (r_rem != 16'd0);

    // Next-state, byte selection and handshake decode for the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_rr_nxt    = r_rr_ptr;
        w_len_nxt   = r_len;
        w_rem_nxt   = r_rem;
        w_csum_nxt  = r_csum;
        w_tmo_nxt   = r_tmo;
        w_pad_nxt   = r_pad;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        w_byte      = 8'h00;
        w_src_ready = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_g_nxt     = w_grant_idx;
                    w_len_nxt   = w_grant_len;
                    w_rem_nxt   = w_grant_len;
                    w_csum_nxt  = 8'h00;
                    w_tmo_nxt   = '0;
                    w_pad_nxt   = 1'b0;
                    w_state_nxt = ST_H0;
                end
            end
            ST_H0: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_byte      = HDR0;
                    w_state_nxt = ST_H1;
                end
            end
            ST_H1: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_byte      = HDR1;
                    w_state_nxt = ST_ID;
                end
            end
            ST_ID: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_byte      = w_id;
                    w_csum_nxt  = r_csum + w_id;
                    w_state_nxt = ST_LENH;
                end
            end
            ST_LENH: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_byte      = r_len[15:8];
                    w_csum_nxt  = r_csum + r_len[15:8];
                    w_state_nxt = ST_LENL;
                end
            end
            ST_LENL: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_byte      = r_len[7:0];
                    w_csum_nxt  = r_csum + r_len[7:0];
                    w_state_nxt = (r_len == 16'd0) ? ST_CSUM : ST_PAY;
                end
            end
            ST_PAY: begin
                if (r_pad) begin
                    // Source stalled too long: finish the frame with zero bytes.
                    if (w_slot_free) begin
                        w_load    = 1'b1;
                        w_byte    = 8'h00;
                        w_rem_nxt = r_rem - 16'd1;
                        if (r_rem == 16'd1) begin
                            w_state_nxt = ST_CSUM;
                        end
                    end
                end else begin
                    w_src_ready[r_g] = w_pay_ok;
                    if (w_pay_ok && src_valid[r_g]) begin
                        w_load     = 1'b1;
                        w_byte     = w_src_byte;
                        w_csum_nxt = r_csum + w_src_byte;
                        w_rem_nxt  = r_rem - 16'd1;
                        w_tmo_nxt  = '0;
                        if (r_rem == 16'd1) begin
                            w_state_nxt = ST_CSUM;
                        end
                    end else if (w_slot_free) begin
                        if (r_tmo == c_TMO_W'(TIMEOUT_CYC - 1)) begin
                            w_pad_nxt = 1'b1;
                            w_err_nxt = 1'b1;
                            w_tmo_nxt = '0;
                        end else begin
                            w_tmo_nxt = r_tmo + 1'b1;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_byte      = r_csum;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Slot free here means the checksum byte has been taken.
                if (w_slot_free) begin
                    w_done_nxt[r_g] = 1'b1;
                    w_rr_nxt        = (r_g == c_IDX_W'(NUM_SRC - 1)) ? '0 : r_g + 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, bookkeeping and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_g      <= '0;
            r_rr_ptr <= '0;
            r_len    <= '0;
            r_rem    <= '0;
            r_csum   <= '0;
            r_tmo    <= '0;
            r_pad    <= 1'b0;
            r_done   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_g      <= w_g_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_len    <= w_len_nxt;
            r_rem    <= w_rem_nxt;
            r_csum   <= w_csum_nxt;
            r_tmo    <= w_tmo_nxt;
            r_pad    <= w_pad_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Output byte register: only reloads when the slot is free, so a stalled byte stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upload_data  <= 8'h00;
            r_upload_valid <= 1'b0;
        end else if (w_slot_free) begin
            r_upload_valid <= w_load;
            if (w_load) begin
                r_upload_data <= w_byte;
            end
        end
    end

    assign upload_data  = r_upload_data;
    assign upload_valid = r_upload_valid;
    assign src_ready    = w_src_ready;
    assign src_done     = r_done;
    assign err_timeout  = r_err;
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_upload_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_upload_arbiter
//  Description : Directed, self-checking bench for upload_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_upload_arbiter;

    localparam int c_NS  = 4;
    localparam int c_TMO = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  src_req = '0;
    logic [63:0] src_len = '0;
    logic [31:0] src_data = '0;
    logic [3:0]  src_valid = '0;
    logic [3:0]  src_ready;
    logic [3:0]  src_done;
    logic [7:0]  upload_data;
    logic        upload_valid;
    logic        upload_ready = 1'b1;
    logic        busy;
    logic        err_timeout;

    upload_arbiter #(
        .NUM_SRC     (c_NS),
        .TIMEOUT_CYC (c_TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_req      (src_req),
        .src_len      (src_len),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_done     (src_done),
        .upload_data  (upload_data),
        .upload_valid (upload_valid),
        .upload_ready (upload_ready),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Source payload stores and observed state.
    logic [7:0] dmem [c_NS][16];
    int         dhead [c_NS];
    int         dcnt  [c_NS];
    logic [3:0] take = '0;
    logic [7:0] got [$];
    int         done_cnt [c_NS];
    int         err_cnt = 0;
    int         rises = 0;
    int         busy_cyc = 0;
    logic [3:0] ready_seen = '0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_busy = 1'b0;

    // Source model: presents the head byte while data remains, pops on transfer.
    initial begin
        for (int s = 0; s < c_NS; s++) begin
            dhead[s] = 0;
            dcnt[s]  = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < c_NS; s++) begin
                if (take[s] && dcnt[s] > 0) begin
                    dhead[s] = dhead[s] + 1;
                    dcnt[s]  = dcnt[s] - 1;
                end
                src_valid[s]       = (dcnt[s] > 0);
                src_data[8*s +: 8] = (dcnt[s] > 0) ? dmem[s][dhead[s]] : 8'h00;
            end
        end
    end

    // Monitor: collects accepted bytes, pulses, and checks stall stability.
    initial begin
        for (int s = 0; s < c_NS; s++) done_cnt[s] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_busy  = 1'b0;
                take       = '0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(upload_valid), 32'd1);
                    chk("hold_data", 32'(upload_data), 32'(prev_data));
                end
                prev_stall = upload_valid && !upload_ready;
                prev_data  = upload_data;
                if (upload_valid && upload_ready) got.push_back(upload_data);
                take       = src_valid & src_ready;
                ready_seen = ready_seen | src_ready;
                for (int s = 0; s < c_NS; s++) begin
                    if (src_done[s]) done_cnt[s] = done_cnt[s] + 1;
                end
                if (err_timeout) err_cnt = err_cnt + 1;
                if (busy) busy_cyc = busy_cyc + 1;
                if (busy && !prev_busy) rises = rises + 1;
                prev_busy = busy;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int          src;
        int          len;
        int          nprov;
        logic [63:0] data;
        bit          bp;
        logic [7:0]  csum;
        int          nerr;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_vector(input vec_t v);
        int   d0;
        int   e0;
        bit   ok;
        logic [7:0] exp_b [$];
        got.delete();
        ready_seen = '0;
        busy_cyc   = 0;
        e0         = err_cnt;
        d0         = done_cnt[v.src];
        for (int i = 0; i < 8; i++) dmem[v.src][i] = v.data[8*i +: 8];
        dhead[v.src] = 0;
        dcnt[v.src]  = v.nprov;
        src_len[16*v.src +: 16] = 16'(v.len);
        src_req[v.src] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy) begin ok = 1'b1; break; end
        end
        chk("grant", 32'(ok), 32'd1);
        src_req[v.src] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (done_cnt[v.src] != d0) begin ok = 1'b1; break; end
            tick();
            if (v.bp) upload_ready = 1'($urandom_range(0, 1));
        end
        upload_ready = 1'b1;
        chk("done_pulse", 32'(ok), 32'd1);
        tick();
        tick();
        exp_b.push_back(8'hAA);
        exp_b.push_back(8'h44);
        exp_b.push_back(8'(v.src));
        exp_b.push_back(8'(v.len >> 8));
        exp_b.push_back(8'(v.len));
        for (int i = 0; i < v.len; i++) exp_b.push_back(v.data[8*i +: 8]);
        exp_b.push_back(v.csum);
        chk("frame_len", 32'(got.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < got.size(); i++) begin
            chk($sformatf("byte[%0d]", i), 32'(got[i]), 32'(exp_b[i]));
        end
        chk("ready_seen", 32'(ready_seen), (v.len > 0) ? (32'd1 << v.src) : 32'd0);
        chk("err_pulses", 32'(err_cnt - e0), 32'(v.nerr));
        chk("done_once", 32'(done_cnt[v.src] - d0), 32'd1);
        if (!v.bp && v.nprov == v.len) chk("busy_cycles", 32'(busy_cyc), 32'(v.len + 7));
    endtask

    initial begin
        logic [7:0] exp_rm [7];
        int r0;
        int d0;
        bit ok;

        vecs[0] = '{src: 1, len: 3, nprov: 3, data: 64'h0000_0000_0030_2010, bp: 1'b0, csum: 8'h64, nerr: 0};
        vecs[1] = '{src: 2, len: 0, nprov: 0, data: 64'h0,                   bp: 1'b0, csum: 8'h02, nerr: 0};
        vecs[2] = '{src: 3, len: 8, nprov: 8, data: 64'h0807_0605_0403_0201, bp: 1'b1, csum: 8'h2F, nerr: 0};
        vecs[3] = '{src: 0, len: 2, nprov: 2, data: 64'h0000_0000_0000_FFFF, bp: 1'b0, csum: 8'h00, nerr: 0};
        vecs[4] = '{src: 3, len: 1, nprov: 1, data: 64'h0000_0000_0000_007F, bp: 1'b0, csum: 8'h83, nerr: 0};
        vecs[5] = '{src: 0, len: 4, nprov: 1, data: 64'h0000_0000_0000_00FF, bp: 1'b0, csum: 8'h03, nerr: 1};

        // Reset state.
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(upload_valid), 32'd0);
        chk("rst_data", 32'(upload_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'd0);
        chk("rst_done", 32'(src_done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 6; v++) run_vector(vecs[v]);

        // Round robin: all four requesting from a fresh pointer.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        got.delete();
        dmem[0][0] = 8'hA0; dmem[0][1] = 8'hA1;
        dmem[1][0] = 8'hB1; dmem[2][0] = 8'hB2; dmem[3][0] = 8'hB3;
        for (int s = 0; s < c_NS; s++) begin
            dhead[s] = 0;
            dcnt[s]  = (s == 0) ? 2 : 1;
            src_len[16*s +: 16] = 16'd1;
        end
        r0 = rises;
        src_req = 4'hF;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (rises - r0 >= 5) begin ok = 1'b1; break; end
        end
        src_req = 4'h0;
        chk("rr_five_grants", 32'(ok), 32'd1);
        for (int k = 0; k < 50 && busy; k++) tick();
        repeat (3) tick();
        chk("rr_bytes", 32'(got.size()), 32'd35);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_id[%0d]", k), 32'(got[7*k + 2]), (k == 4) ? 32'd0 : 32'(k));
        end
        chk("rr_second_src0_byte", 32'(got[33]), 32'hA1);

        // Reset in the middle of a payload.
        got.delete();
        for (int i = 0; i < 8; i++) dmem[3][i] = 8'(8'h40 + i);
        dhead[3] = 0;
        dcnt[3]  = 8;
        src_len[63:48] = 16'd8;
        src_req[3] = 1'b1;
        for (int k = 0; k < 20 && !busy; k++) tick();
        src_req[3] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (got.size() >= 7) begin ok = 1'b1; break; end
        end
        chk("mid_pay_reached", 32'(ok), 32'd1);
        d0 = done_cnt[3];
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(upload_valid), 32'd0);
        chk("arst_data", 32'(upload_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(src_ready), 32'd0);
        chk("arst_done", 32'(src_done), 32'd0);
        chk("arst_err", 32'(err_timeout), 32'd0);
        for (int s = 0; s < c_NS; s++) dcnt[s] = 0;
        repeat (3) tick();
        chk("arst_no_done", 32'(done_cnt[3] - d0), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fresh frame after reset; pointer back at 0 picks src 0 over src 2.
        got.delete();
        dmem[0][0] = 8'h5A; dhead[0] = 0; dcnt[0] = 1;
        dmem[2][0] = 8'hC3; dhead[2] = 0; dcnt[2] = 1;
        src_len[15:0]  = 16'd1;
        src_len[47:32] = 16'd1;
        d0 = done_cnt[0];
        src_req = 4'b0101;
        for (int k = 0; k < 20 && !busy; k++) tick();
        src_req = 4'b0000;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done_cnt[0] != d0) begin ok = 1'b1; break; end
            tick();
        end
        chk("post_rst_done", 32'(ok), 32'd1);
        tick();
        tick();
        exp_rm = '{8'hAA, 8'h44, 8'h00, 8'h00, 8'h01, 8'h5A, 8'h5B};
        chk("post_rst_len", 32'(got.size()), 32'd7);
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            chk($sformatf("post_rst_byte[%0d]", i), 32'(got[i]), 32'(exp_rm[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
